// File: rtl/jt1943_obj_busarb.sv
// Main-CPU side arbiter for the object DMA: halts the Z80 through BUSRQ/BUSAK, grants the
// shared object RAM to the object engine, and generates the OKOUT list-ready strobe.
module jt1943_obj_busarb #(
  parameter int TIMEOUT = 1023,
  parameter int ABW     = 13
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen6,
  input  logic           cpu_cen,
  input  logic           bus_req,
  output logic           bus_ack,
  input  logic           blcnten,
  input  logic [ABW-1:0] obj_AB,
  output logic [7:0]     obj_DB,
  input  logic [ABW-1:0] cpu_AB,
  output logic [ABW-1:0] ram_addr,
  input  logic [7:0]     ram_dout,
  output logic           cpu_busrq_n,
  input  logic           cpu_busak_n,
  input  logic           okout_wr,
  output logic           OKOUT,
  output logic [8:0]     xfer_cnt,
  output logic           abort_err
);

  // state | meaning
  // IDLE  | Z80 owns the bus, waiting for a request on a cen6 tick
  // REQ   | BUSRQ asserted, waiting for BUSAK (timed out by the watchdog)
  // GRANT | object engine owns the RAM, bytes flow to obj_DB
  // REL   | grant withdrawn, BUSRQ held until the next cen6 tick
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;
  localparam logic [1:0] REL   = 2'd3;

  logic [1:0] state;
  logic [9:0] timer;
  logic       ok_pend;

  // Watchdog is a down-counter: loaded on REQ entry, abort on terminal count after TIMEOUT clks
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      obj_DB    <= '0;
      xfer_cnt  <= '0;
      abort_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cen6 && bus_req) begin
            state    <= REQ;
            xfer_cnt <= '0;
            timer    <= 10'(TIMEOUT - 1);
          end
        end
        REQ: begin
          if (!bus_req) begin
            state <= REL;
          end else if (cpu_cen && !cpu_busak_n) begin
            state <= GRANT;
          end else if (timer == 10'd0) begin
            state     <= REL;
            abort_err <= 1'b1;
          end else begin
            timer <= timer - 10'd1;
          end
        end
        GRANT: begin
          obj_DB <= ram_dout;
          if (cen6 && blcnten && xfer_cnt != 9'd511) xfer_cnt <= xfer_cnt + 9'd1;
          if (!bus_req) state <= REL;
        end
        REL: begin
          if (cen6) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // OKOUT spans exactly one cen6 period; writes while pending or pulsing are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_pend <= 1'b0;
      OKOUT   <= 1'b0;
    end else begin
      if (okout_wr && !ok_pend && !OKOUT) ok_pend <= 1'b1;
      if (cen6) begin
        if (OKOUT) begin
          OKOUT <= 1'b0;
        end else if (ok_pend) begin
          OKOUT   <= 1'b1;
          ok_pend <= 1'b0;
        end
      end
    end
  end

  assign bus_ack     = (state == GRANT);
  assign cpu_busrq_n = (state == IDLE);
  assign ram_addr    = (state == GRANT) ? obj_AB : cpu_AB;

endmodule

// File: tb/tb_jt1943_obj_busarb.sv
// Directed bench for jt1943_obj_busarb: Z80 BUSRQ/BUSAK model, pattern RAM model and
// hand-computed expectations for handshake, byte count, timeout, reset and OKOUT.
module tb_jt1943_obj_busarb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen6 = 1'b0;
  logic        cpu_cen = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_ack;
  logic        blcnten = 1'b0;
  logic [12:0] obj_AB = 13'h0000;
  logic [7:0]  obj_DB;
  logic [12:0] cpu_AB = 13'h0555;
  logic [12:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic        okout_wr = 1'b0;
  logic        OKOUT;
  logic [8:0]  xfer_cnt;
  logic        abort_err;

  logic z80_ak_n = 1'b1;
  logic man_ak_n = 1'b1;
  logic z80_auto = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  assign cpu_busak_n = z80_ak_n & man_ak_n;
  // RAM contents are a fixed function of the address
  assign ram_dout = ram_addr[7:0] ^ {3'b000, ram_addr[12:8]} ^ 8'h5A;

  jt1943_obj_busarb #(.TIMEOUT(1023), .ABW(13)) dut (
    .clk(clk), .rst(rst), .cen6(cen6), .cpu_cen(cpu_cen),
    .bus_req(bus_req), .bus_ack(bus_ack), .blcnten(blcnten),
    .obj_AB(obj_AB), .obj_DB(obj_DB), .cpu_AB(cpu_AB), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .cpu_busrq_n(cpu_busrq_n), .cpu_busak_n(cpu_busak_n),
    .okout_wr(okout_wr), .OKOUT(OKOUT), .xfer_cnt(xfer_cnt), .abort_err(abort_err)
  );

  always #5 clk = ~clk;

  // Clock enables (cen6 every 4 clk, cpu_cen every 3 clk) and the Z80 BUSAK model
  initial begin : strobes
    int cnt;
    int ncc;
    cnt = 0;
    ncc = 0;
    forever begin
      @(negedge clk);
      cen6    = (cnt % 4 == 0);
      cpu_cen = (cnt % 3 == 0);
      cnt++;
      if (z80_auto && !cpu_busrq_n) begin
        if (ncc >= 3) z80_ak_n = 1'b0;
        if (cpu_cen) ncc++;
      end else begin
        ncc      = 0;
        z80_ak_n = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for busrq_n to reach lvl; reports cen6 as sampled at the transition edge
  task automatic wait_busrq(input logic lvl, input string tag, output logic c6);
    bit done;
    done = 1'b0;
    c6   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      c6 = cen6;
      #1;
      if (cpu_busrq_n == lvl) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({tag, "_busrq_timeout"}, 32'd0, 32'd1);
  endtask

  // Waits for bus_ack; reports whether the transition edge had cpu_cen with busak low
  task automatic wait_ack(input string tag, output logic sampled);
    bit done;
    done    = 1'b0;
    sampled = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      sampled = cpu_cen & ~cpu_busak_n;
      #1;
      if (bus_ack) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic count_cen6(input int target, output int got);
    got = 0;
    for (int i = 0; i < 4 * target + 50; i++) begin
      @(posedge clk);
      if (cen6) got++;
      #1;
      if (got == target) break;
    end
  endtask

  initial begin : main
    logic c6, smp;
    int   n;
    bit   saw_ack;
    int   rises, highs;
    logic prev, rise_c6;

    repeat (4) step();
    rst = 1'b0;
    check("rst_bus_ack", 32'(bus_ack), 32'd0);
    check("rst_busrq_n", 32'(cpu_busrq_n), 32'd1);
    check("rst_obj_db", 32'(obj_DB), 32'd0);
    check("rst_okout", 32'(OKOUT), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_abort_err", 32'(abort_err), 32'd0);
    check("idle_ram_addr", 32'(ram_addr), 32'h0555);

    // Handshake with a Z80 that acknowledges after 3 cpu_cen
    z80_auto = 1'b1;
    bus_req  = 1'b1;
    wait_busrq(1'b0, "hs", c6);
    check("hs_busrq_on_cen6", 32'(c6), 32'd1);
    wait_ack("hs", smp);
    check("hs_ack_after_busak", 32'(smp), 32'd1);
    obj_AB = 13'h1A00;
    #1;
    check("grant_ram_addr", 32'(ram_addr), 32'h1A00);
    step();
    check("obj_db_1a00", 32'(obj_DB), 32'h40);
    obj_AB = 13'h0123;
    step();
    check("obj_db_0123", 32'(obj_DB), 32'h78);

    // 384 counted bytes, then release
    blcnten = 1'b1;
    count_cen6(384, n);
    blcnten = 1'b0;
    check("xfer_384", 32'(xfer_cnt), 32'd384);
    bus_req = 1'b0;
    step();
    check("rel_bus_ack", 32'(bus_ack), 32'd0);
    check("rel_busrq_held", 32'(cpu_busrq_n), 32'd0);
    check("rel_ram_addr", 32'(ram_addr), 32'h0555);
    wait_busrq(1'b1, "rel", c6);
    check("rel_busrq_on_cen6", 32'(c6), 32'd1);
    check("rel_xfer_hold", 32'(xfer_cnt), 32'd384);

    // Saturation at 511
    bus_req = 1'b1;
    wait_busrq(1'b0, "sat", c6);
    wait_ack("sat", smp);
    check("sat_xfer_cleared", 32'(xfer_cnt), 32'd0);
    blcnten = 1'b1;
    count_cen6(520, n);
    blcnten = 1'b0;
    check("xfer_saturate", 32'(xfer_cnt), 32'd511);
    bus_req = 1'b0;
    wait_busrq(1'b1, "sat", c6);

    // Z80 never acknowledges: abort after 1023 clk in REQ
    z80_auto = 1'b0;
    bus_req  = 1'b1;
    wait_busrq(1'b0, "to", c6);
    n       = 0;
    saw_ack = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      step();
      n++;
      if (bus_ack) saw_ack = 1'b1;
      if (abort_err) break;
    end
    bus_req = 1'b0;
    check("timeout_clks", 32'(n), 32'd1023);
    check("timeout_abort_err", 32'(abort_err), 32'd1);
    wait_busrq(1'b1, "to", c6);
    if (bus_ack) saw_ack = 1'b1;
    check("timeout_busrq_on_cen6", 32'(c6), 32'd1);
    check("timeout_no_ack", 32'(saw_ack), 32'd0);

    // bus_req drops on the same clk BUSAK is sampled low
    bus_req = 1'b1;
    wait_busrq(1'b0, "race", c6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (cpu_cen) begin
        man_ak_n = 1'b0;
        bus_req  = 1'b0;
        break;
      end
    end
    saw_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_ack) saw_ack = 1'b1;
    end
    man_ak_n = 1'b1;
    check("race_no_ack", 32'(saw_ack), 32'd0);
    check("race_busrq_released", 32'(cpu_busrq_n), 32'd1);
    check("race_abort_sticky", 32'(abort_err), 32'd1);

    // Reset in the middle of a grant
    z80_auto = 1'b1;
    bus_req  = 1'b1;
    wait_busrq(1'b0, "rg", c6);
    wait_ack("rg", smp);
    blcnten = 1'b1;
    repeat (12) step();
    blcnten = 1'b0;
    check("rg_xfer_3", 32'(xfer_cnt), 32'd3);
    rst = 1'b1;
    step();
    check("rg_bus_ack", 32'(bus_ack), 32'd0);
    check("rg_busrq_n", 32'(cpu_busrq_n), 32'd1);
    check("rg_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rg_abort_err", 32'(abort_err), 32'd0);
    rst     = 1'b0;
    bus_req = 1'b0;
    repeat (4) step();

    // Two OKOUT writes 2 clk apart give a single one-cen6-period pulse
    rises   = 0;
    highs   = 0;
    prev    = OKOUT;
    rise_c6 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      okout_wr = (i == 0 || i == 2);
      @(posedge clk);
      c6 = cen6;
      #1;
      if (OKOUT && !prev) begin
        rises++;
        rise_c6 = c6;
      end
      if (OKOUT) highs++;
      prev = OKOUT;
    end
    okout_wr = 1'b0;
    check("okout_pulses", 32'(rises), 32'd1);
    check("okout_width", 32'(highs), 32'd4);
    check("okout_on_cen6", 32'(rise_c6), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
